// File: rtl/chase_game_pkg.sv
// Shared types and constants for the LED chase / reaction game controller.
package chase_game_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLASH, OVER} state_t;

    localparam int POS_W   = 3;
    localparam int SCORE_W = 4;
    localparam int LIVES_W = 2;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd15;
    localparam logic [POS_W-1:0]   POS_OFF   = 3'd0;
    localparam logic [POS_W-1:0]   POS_FIRST = 3'd1;
    localparam logic [POS_W-1:0]   POS_LAST  = 3'd7;

    // Chaser walks 1..7 and wraps back to 1; 0 is reserved for "all off".
    function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] pos);
        return (pos == POS_LAST) ? POS_FIRST : pos + POS_W'(1);
    endfunction

endpackage

// File: rtl/chase_tick_gen.sv
// Step-tick generator: loadable period register plus a clearable, enabled counter.
module chase_tick_gen #(
    parameter int CNT_W    = 24,
    parameter int DIV_INIT = 12000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clr,
    input  logic             en,
    output logic             tick,
    output logic [CNT_W-1:0] period
);

    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] count_reg;

    // Decoded from registered state only, so the caller may use it to build clr.
    assign tick   = en && (count_reg == period_reg - CNT_W'(1));
    assign period = period_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            period_reg <= CNT_W'(DIV_INIT);
        end else if (load) begin
            period_reg <= load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= tick ? '0 : count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/chase_game_ctrl.sv
// Game sequencer: state, chase speed, score and lives for the LED chase game.
// Optional high-score register is enabled by defining CHASE_HISCORE_EN.
module chase_game_ctrl
    import chase_game_pkg::*;
#(
    parameter int DIV_INIT    = 12000000,
    parameter int DIV_STEP    = 1000000,
    parameter int DIV_MIN     = 2000000,
    parameter int CNT_W       = 24,
    parameter int LIVES       = 3,
    parameter int TARGET_POS  = 7,
    parameter int FLASH_TICKS = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               btn_pulse,
    output logic [POS_W-1:0]   led_pos,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic               playing,
    output logic               game_over,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic [SCORE_W-1:0] hiscore
);

    localparam int FL_W = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
    localparam logic [CNT_W:0] CLAMP_AT = (CNT_W+1)'(DIV_MIN + DIV_STEP);

    state_t             state_reg, state_next;
    logic [POS_W-1:0]   led_pos_reg, led_pos_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [LIVES_W-1:0] lives_reg, lives_next;
    logic [FL_W-1:0]    flash_cnt_reg, flash_cnt_next;
    logic               hit_reg, hit_next;
    logic               miss_reg, miss_next;
    logic               playing_reg, game_over_reg;
    logic               tick, clr, load, lose;
    logic [CNT_W-1:0]   period, load_val;

    chase_tick_gen #(
        .CNT_W    (CNT_W),
        .DIV_INIT (DIV_INIT)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .clr      (clr),
        .en       ((state_reg == RUN) || (state_reg == FLASH)),
        .tick     (tick),
        .period   (period)
    );

    // A restart keeps the state at RUN, so it must clear the counter explicitly.
    assign clr = start || (state_next != state_reg);

    always_comb begin
        state_next     = state_reg;
        led_pos_next   = led_pos_reg;
        score_next     = score_reg;
        lives_next     = lives_reg;
        flash_cnt_next = flash_cnt_reg;
        hit_next       = 1'b0;
        miss_next      = 1'b0;
        load           = 1'b0;
        load_val       = period;
        lose           = 1'b0;

        if (start) begin
            state_next     = RUN;
            led_pos_next   = POS_FIRST;
            score_next     = '0;
            lives_next     = LIVES_W'(LIVES);
            flash_cnt_next = '0;
            load           = 1'b1;
            load_val       = CNT_W'(DIV_INIT);
        end else begin
            unique case (state_reg)
                RUN: begin
                    if (btn_pulse && led_pos_reg == POS_W'(TARGET_POS)) begin
                        // A scoring press swallows any tick arriving in the same cycle.
                        state_next     = FLASH;
                        led_pos_next   = POS_OFF;
                        score_next     = (score_reg == SCORE_MAX) ? score_reg
                                                                  : score_reg + SCORE_W'(1);
                        flash_cnt_next = '0;
                        hit_next       = 1'b1;
                        load           = 1'b1;
                        load_val       = ({1'b0, period} >= CLAMP_AT)
                                       ? period - CNT_W'(DIV_STEP) : CNT_W'(DIV_MIN);
                    end else begin
                        lose = btn_pulse || (tick && led_pos_reg == POS_W'(TARGET_POS));
                        if (lose && lives_reg == LIVES_W'(1)) begin
                            state_next   = OVER;
                            led_pos_next = POS_OFF;
                        end else if (tick) begin
                            led_pos_next = next_pos(led_pos_reg);
                        end
                        if (lose) begin
                            lives_next = lives_reg - LIVES_W'(1);
                            miss_next  = 1'b1;
                        end
                    end
                end
                FLASH: begin
                    if (tick) begin
                        if (flash_cnt_reg == FL_W'(FLASH_TICKS - 1)) begin
                            state_next     = RUN;
                            led_pos_next   = POS_FIRST;
                            flash_cnt_next = '0;
                        end else begin
                            flash_cnt_next = flash_cnt_reg + FL_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            led_pos_reg   <= POS_OFF;
            score_reg     <= '0;
            lives_reg     <= '0;
            flash_cnt_reg <= '0;
            hit_reg       <= 1'b0;
            miss_reg      <= 1'b0;
            playing_reg   <= 1'b0;
            game_over_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            led_pos_reg   <= led_pos_next;
            score_reg     <= score_next;
            lives_reg     <= lives_next;
            flash_cnt_reg <= flash_cnt_next;
            hit_reg       <= hit_next;
            miss_reg      <= miss_next;
            playing_reg   <= (state_next == RUN) || (state_next == FLASH);
            game_over_reg <= (state_next == OVER);
        end
    end

`ifdef CHASE_HISCORE_EN
    logic [SCORE_W-1:0] hiscore_reg;

    // Start has priority in the next-state logic, so OVER entry never coincides with a restart.
    always_ff @(posedge clk) begin
        if (reset) begin
            hiscore_reg <= '0;
        end else if (state_next == OVER && state_reg != OVER && score_next > hiscore_reg) begin
            hiscore_reg <= score_next;
        end
    end

    assign hiscore = hiscore_reg;
`else
    assign hiscore = '0;
`endif

    assign led_pos    = led_pos_reg;
    assign score      = score_reg;
    assign lives      = lives_reg;
    assign playing    = playing_reg;
    assign game_over  = game_over_reg;
    assign hit_pulse  = hit_reg;
    assign miss_pulse = miss_reg;

endmodule

// File: tb/tb_chase_game_ctrl.sv
// Directed bench for chase_game_ctrl: a game-rules model checked every cycle plus literal pins.
module tb_chase_game_ctrl;

    localparam int P_INIT  = 8;
    localparam int P_STEP  = 2;
    localparam int P_MIN   = 4;
    localparam int N_LIVES = 3;
    localparam int TGT     = 7;
    localparam int N_FLASH = 2;
`ifdef CHASE_HISCORE_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLASH = 2;
    localparam int M_OVER  = 3;

    logic       clk = 1'b0;
    logic       reset, start, btn_pulse;
    logic [2:0] led_pos;
    logic [3:0] score, hiscore;
    logic [1:0] lives;
    logic       playing, game_over, hit_pulse, miss_pulse;

    always #5 clk = ~clk;

    chase_game_ctrl #(
        .DIV_INIT    (P_INIT),
        .DIV_STEP    (P_STEP),
        .DIV_MIN     (P_MIN),
        .CNT_W       (24),
        .LIVES       (N_LIVES),
        .TARGET_POS  (TGT),
        .FLASH_TICKS (N_FLASH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .btn_pulse  (btn_pulse),
        .led_pos    (led_pos),
        .score      (score),
        .lives      (lives),
        .playing    (playing),
        .game_over  (game_over),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .hiscore    (hiscore)
    );

    // Game model: mode, cycles elapsed in current step, step length, chaser, score, lives.
    int m_mode, m_elapsed, m_period, m_pos, m_score, m_lives, m_flashes, m_hit, m_miss, m_hi;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic lose_life(input bit advance);
        m_lives -= 1;
        m_miss = 1;
        if (m_lives == 0) begin
            m_mode = M_OVER;
            m_pos = 0;
            m_elapsed = 0;
            if (HI_EN && m_score > m_hi) m_hi = m_score;
        end else if (advance) begin
            m_pos = (m_pos == 7) ? 1 : m_pos + 1;
        end
    endtask

    task automatic model_step(input bit rst, input bit st, input bit b);
        bit tk;
        m_hit = 0;
        m_miss = 0;
        if (rst) begin
            m_mode = M_IDLE; m_elapsed = 0; m_period = P_INIT; m_pos = 0;
            m_score = 0; m_lives = 0; m_flashes = 0; m_hi = 0;
        end else if (st) begin
            m_mode = M_RUN; m_elapsed = 0; m_period = P_INIT; m_pos = 1;
            m_score = 0; m_lives = N_LIVES; m_flashes = 0;
        end else if (m_mode == M_RUN) begin
            tk = (m_elapsed == m_period - 1);
            m_elapsed = tk ? 0 : m_elapsed + 1;
            if (b && m_pos == TGT) begin
                m_hit = 1;
                m_score = (m_score < 15) ? m_score + 1 : 15;
                m_period = (m_period - P_STEP < P_MIN) ? P_MIN : m_period - P_STEP;
                m_mode = M_FLASH; m_pos = 0; m_elapsed = 0; m_flashes = 0;
            end else if (b) begin
                lose_life(tk);
            end else if (tk) begin
                if (m_pos == TGT) lose_life(1'b1);
                else m_pos = m_pos + 1;
            end
        end else if (m_mode == M_FLASH) begin
            tk = (m_elapsed == m_period - 1);
            m_elapsed = tk ? 0 : m_elapsed + 1;
            if (tk) begin
                m_flashes++;
                if (m_flashes == N_FLASH) begin
                    m_mode = M_RUN; m_pos = 1; m_elapsed = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("led_pos", int'(led_pos), m_pos);
        check("score", int'(score), m_score);
        check("lives", int'(lives), m_lives);
        check("playing", int'(playing), int'(m_mode == M_RUN || m_mode == M_FLASH));
        check("game_over", int'(game_over), int'(m_mode == M_OVER));
        check("hit_pulse", int'(hit_pulse), m_hit);
        check("miss_pulse", int'(miss_pulse), m_miss);
        check("hiscore", int'(hiscore), m_hi);
    endtask

    task automatic cycle(input bit rst, input bit st, input bit b);
        reset = rst; start = st; btn_pulse = b;
        @(posedge clk);
        model_step(rst, st, b);
        @(negedge clk);
        compare_all();
        reset = 1'b0; start = 1'b0; btn_pulse = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_pos(input int p, input bit at_tick, input string tag);
        int n = 0;
        while (!(m_mode == M_RUN && m_pos == p && (!at_tick || m_elapsed == m_period - 1))
               && n < 400) begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
        end
        if (!(m_mode == M_RUN && m_pos == p)) begin
            checks++; errors++;
            $display("FAIL %s: timed out waiting for position %0d", tag, p);
        end
    endtask

    task automatic wait_over(input string tag);
        int n = 0;
        while (m_mode != M_OVER && n < 600) begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
        end
        if (m_mode != M_OVER) begin
            checks++; errors++;
            $display("FAIL %s: timed out waiting for game over", tag);
        end
    endtask

    task automatic play_game(input int hits);
        cycle(1'b0, 1'b1, 1'b0);
        for (int h = 0; h < hits; h++) begin
            wait_pos(TGT, 1'b0, "play_wait");
            cycle(1'b0, 1'b0, 1'b1);
        end
        wait_over("play_over");
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; btn_pulse = 1'b0;

        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        idle(50);
        check("idle_led", int'(led_pos), 0);
        check("idle_score", int'(score), 0);
        check("idle_lives", int'(lives), 0);
        check("idle_playing", int'(playing), 0);
        $display("txn reset_idle: led_pos=%0d score=%0d lives=%0d", led_pos, score, lives);

        cycle(1'b0, 1'b1, 1'b0);
        check("start_led", int'(led_pos), 1);
        check("start_lives", int'(lives), 3);
        idle(7);
        check("step1_hold", int'(led_pos), 1);
        idle(1);
        check("step2", int'(led_pos), 2);
        idle(47);
        check("pre_miss_led", int'(led_pos), 7);
        idle(1);
        check("tick_miss_pulse", int'(miss_pulse), 1);
        check("tick_miss_lives", int'(lives), 2);
        check("tick_miss_wrap", int'(led_pos), 1);
        wait_over("no_press_over");
        check("over_flag", int'(game_over), 1);
        check("over_led", int'(led_pos), 0);
        $display("txn no_press_game: game_over=%0d lives=%0d", game_over, lives);

        cycle(1'b0, 1'b1, 1'b0);
        wait_pos(TGT, 1'b0, "hit1_wait");
        cycle(1'b0, 1'b0, 1'b1);
        check("hit1_pulse", int'(hit_pulse), 1);
        check("hit1_score", int'(score), 1);
        check("hit1_led", int'(led_pos), 0);
        idle(11);
        check("flash6_end", int'(led_pos), 0);
        idle(1);
        check("resume6", int'(led_pos), 1);
        idle(5);
        check("period6_hold", int'(led_pos), 1);
        idle(1);
        check("period6_step", int'(led_pos), 2);
        for (int h = 0; h < 2; h++) begin
            wait_pos(TGT, 1'b0, "hit23_wait");
            cycle(1'b0, 1'b0, 1'b1);
        end
        idle(7);
        check("flash4_end", int'(led_pos), 0);
        idle(1);
        check("resume4", int'(led_pos), 1);
        idle(3);
        check("period4_hold", int'(led_pos), 1);
        idle(1);
        check("period4_step", int'(led_pos), 2);
        $display("txn hits_speedup: score=%0d", score);

        cycle(1'b0, 1'b1, 1'b0);
        wait_pos(3, 1'b0, "miss3_wait");
        cycle(1'b0, 1'b0, 1'b1);
        check("press_miss_pulse", int'(miss_pulse), 1);
        check("press_miss_lives", int'(lives), 2);
        check("press_miss_led", int'(led_pos), 3);
        wait_pos(TGT, 1'b1, "coinc_wait");
        cycle(1'b0, 1'b0, 1'b1);
        check("coinc_hit", int'(hit_pulse), 1);
        check("coinc_nomiss", int'(miss_pulse), 0);
        check("coinc_lives", int'(lives), 2);
        $display("txn miss_and_coincident: lives=%0d score=%0d", lives, score);

        cycle(1'b0, 1'b1, 1'b0);
        for (int h = 0; h < 16; h++) begin
            wait_pos(TGT, 1'b0, "sat_wait");
            cycle(1'b0, 1'b0, 1'b1);
        end
        check("sat_score", int'(score), 15);
        idle(2);
        cycle(1'b1, 1'b0, 1'b0);
        check("rst_led", int'(led_pos), 0);
        check("rst_score", int'(score), 0);
        check("rst_lives", int'(lives), 0);
        check("rst_playing", int'(playing), 0);
        $display("txn saturate_then_reset: score=%0d playing=%0d", score, playing);

        play_game(5);
        play_game(3);
        check("hiscore_kept", int'(hiscore), HI_EN ? 5 : 0);
        cycle(1'b0, 1'b1, 1'b0);
        check("hiscore_start", int'(hiscore), HI_EN ? 5 : 0);
        cycle(1'b1, 1'b0, 1'b0);
        check("hiscore_reset", int'(hiscore), 0);
        $display("txn hiscore: enabled=%0d hiscore=%0d", HI_EN, hiscore);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chase_game_ctrl.md
Name: chase_game_ctrl

Overview:
- Sequencer for the LED chase / reaction game: owns game state, chase speed, score and lives.
- Produces the chaser position consumed by the LED demux and the score consumed by the 7-segment decoder.
- Consumes the debounced button as a one-cycle pulse.
- Replaces the fixed divider + free-running counter + AND-gate scoring with one controlled block.

Parameters:
- DIV_INIT, 12000000, clk cycles per chase step at game start.
- DIV_STEP, 1000000, cycles removed from the step period after each hit.
- DIV_MIN, 2000000, floor on the step period.
- CNT_W, 24, width of the tick counter and period register; must hold DIV_INIT.
- LIVES, 3, misses allowed per game; range 1..3.
- TARGET_POS, 7, chaser position that scores when pressed.
- FLASH_TICKS, 2, steps spent in FLASH after a hit.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; all state cleared on the clk edge where it is high.
- start  in  1  single-cycle pulse; begins or restarts a game.
- btn_pulse  in  1  debounced press, one cycle wide.
- led_pos  out  3  chaser position 1..7; 0 = all LEDs off.
- score  out  4  hits this game, saturates at 15.
- lives  out  2  remaining lives.
- playing  out  1  high in RUN or FLASH.
- game_over  out  1  high in OVER.
- hit_pulse  out  1  one cycle, registered, on a scored press.
- miss_pulse  out  1  one cycle, registered, on a lost life.
- hiscore  out  4  see Optional Feature.

Behaviour:
- Reset values: state IDLE, led_pos 0, score 0, lives 0, period DIV_INIT, tick counter 0, all pulses 0, hiscore 0.
- Tick generation: counter runs only in RUN and FLASH. When count == period-1, tick=1 for one cycle and count returns to 0. The counter is cleared on every state change.
- IDLE: led_pos=0. On start go to RUN with score=0, lives=LIVES, period=DIV_INIT, led_pos=1.
- RUN, on tick: led_pos advances 1→2→…→7→1.
- RUN, btn_pulse with led_pos==TARGET_POS (hit):
  - score+1, saturating at 15;
  - period = max(period-DIV_STEP, DIV_MIN);
  - hit_pulse next cycle;
  - go to FLASH with led_pos=0.
- RUN, btn_pulse with led_pos!=TARGET_POS (miss): lives-1 and miss_pulse. If lives becomes 0, go to OVER; otherwise stay in RUN with led_pos unchanged.
- RUN, tick while led_pos==TARGET_POS with no press in that step: counts as a miss, same rules as above. led_pos still wraps to 1 if not entering OVER.
- Tick and btn_pulse in the same cycle: the press is judged against the pre-tick led_pos. If the press hits, the tick is discarded. If the press misses, do not also count the tick-based miss in that cycle; at most one life is lost per cycle.
- FLASH: led_pos=0. After FLASH_TICKS ticks go to RUN with led_pos=1. btn_pulse is ignored.
- OVER: led_pos=0; score and lives are held; btn_pulse is ignored. On start, restart exactly as from IDLE.
- start in RUN or FLASH: immediate restart, same as from IDLE.
- reset mid-game: overrides everything, giving the reset values above.
- Output timing: all outputs are registered. led_pos updates the cycle after the tick.

Optional Feature:
- Macro: CHASE_HISCORE_EN.
- When defined: on entry to OVER, hiscore <= score if score > hiscore. hiscore is cleared only by reset, not by start.
- When undefined: hiscore is tied to 4'd0 and no register is inferred.

Decomposition:
- Package chase_game_pkg holds:
  - state enum: IDLE, RUN, FLASH, OVER;
  - POS_W=3, SCORE_W=4, LIVES_W=2;
  - SCORE_MAX=15, POS_OFF=0, POS_FIRST=1, POS_LAST=7.
- One sub-module, chase_tick_gen: loadable period register plus counter with clear and enable, producing the tick strobe.

Test Plan (DIV_INIT=8, DIV_STEP=2, DIV_MIN=4, FLASH_TICKS=2):
- Reset then idle 50 cycles -> led_pos=0, score=0, lives=0, playing=0; no pulses.
- start, no presses -> led_pos 1..7 advancing every 8 cycles. Each pass of pos 7 yields miss_pulse; lives 3→2→1→0, then game_over=1 and led_pos=0.
- Press while led_pos==7 -> hit_pulse; score=1; 2 ticks of led_pos=0; resume at 1 with period 6. Further hits give periods 4, 4 (clamped at DIV_MIN).
- Press while led_pos==3 -> miss_pulse, lives 3→2, led_pos stays 3. Press coincident with tick leaving pos 7 -> hit, no miss, lives unchanged.
- 16 hits -> score saturates at 15. reset asserted mid-FLASH -> all reset values next cycle.
- CHASE_HISCORE_EN: game ending at score 5, then game ending at 3 -> hiscore=5. A start does not clear it; reset does. Without the macro, hiscore=0 throughout.
